// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared constants, op encodings and FSM state for the mul/div unit
// Rev 1.0
// ============================================================================
package mips_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIN  = 2'd2
    } md_state_e;

    // Magnitude of a possibly-signed operand; 0x80000000 maps to itself as unsigned.
    function automatic logic [XLEN-1:0] md_mag(input logic [XLEN-1:0] x, input logic is_signed);
        return (is_signed && x[XLEN-1]) ? (~x + 1'b1) : x;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_core.sv
`default_nettype none
// ============================================================================
// mips_muldiv_core : radix-2 shift-add multiply / restoring divide on magnitudes
// Rev 1.0
// ============================================================================
module mips_muldiv_core
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic            is_div,
    input  logic [XLEN-1:0] a_mag,
    input  logic [XLEN-1:0] b_mag,
    output logic [XLEN-1:0] hi_raw,
    output logic [XLEN-1:0] lo_raw
);

    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic              is_div_q, is_div_d;
    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shifted;
    logic [XLEN:0]     w_diff;

    // Multiply: acc = {partial product, multiplier}. Divide: acc = {remainder, quotient}.
    always_comb begin
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        is_div_d  = is_div_q;
        w_sum     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        w_shifted = acc_q[2*XLEN-1:XLEN-1];
        w_diff    = w_shifted - {1'b0, opnd_q};
        if (load) begin
            is_div_d = is_div;
            opnd_d   = is_div ? b_mag : a_mag;
            acc_d    = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        end else if (step) begin
            if (is_div_q) begin
                if (!w_diff[XLEN])
                    acc_d = {w_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                else
                    acc_d = {w_shifted[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
            end else begin
                acc_d = {w_sum, acc_q[XLEN-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            is_div_q <= is_div_d;
        end
    end

    assign hi_raw = acc_q[2*XLEN-1:XLEN];
    assign lo_raw = acc_q[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// mips_muldiv_unit : iterative MULT/MULTU/DIV/DIVU with HI/LO and start/busy/done
// Rev 1.0
// ============================================================================
module mips_muldiv_unit
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            mthi,
    input  logic            mtlo,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(XLEN - 1);

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic              neg_lo_q, neg_lo_d;
    logic              neg_hi_q, neg_hi_d;
    logic              div0_q, div0_d;
    logic [XLEN-1:0]   a_raw_q, a_raw_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;

    logic              w_load;
    logic              w_step;
    logic              w_signed;
    logic [XLEN-1:0]   w_hi_raw;
    logic [XLEN-1:0]   w_lo_raw;
    logic [2*XLEN-1:0] w_prod;

    assign w_signed = ~op[0];
    assign w_prod   = {w_hi_raw, w_lo_raw};

    mips_muldiv_core u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_load),
        .step   (w_step),
        .is_div (op[1]),
        .a_mag  (md_mag(a, w_signed)),
        .b_mag  (md_mag(b, w_signed)),
        .hi_raw (w_hi_raw),
        .lo_raw (w_lo_raw)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        a_raw_d  = a_raw_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        w_load   = 1'b0;
        w_step   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    w_load   = 1'b1;
                    state_d  = ST_CALC;
                    cnt_d    = '0;
                    op_d     = op;
                    neg_lo_d = w_signed & (a[XLEN-1] ^ b[XLEN-1]);
                    neg_hi_d = w_signed & op[1] & a[XLEN-1];
                    div0_d   = op[1] & (b == '0);
                    a_raw_d  = a;
                end else if (!start) begin
                    // A start in the same cycle blocks HI/LO moves, even if flushed.
                    if (mthi) hi_d = wdata;
                    if (mtlo) lo_d = wdata;
                end
            end
            ST_CALC: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    w_step = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == C_LAST) state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (op_q[1]) begin
                        if (div0_q) begin
                            lo_d = '1;
                            hi_d = a_raw_q;
                        end else begin
                            lo_d = neg_lo_q ? -w_lo_raw : w_lo_raw;
                            hi_d = neg_hi_q ? -w_hi_raw : w_hi_raw;
                        end
                    end else begin
                        {hi_d, lo_d} = neg_lo_q ? -w_prod : w_prod;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= MD_MULT;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            a_raw_q  <= a_raw_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire
